// File: rtl/demux_capture.sv
// demux_capture: sequential 1:N bit collector. Each accepted beat writes in_bit
// into word position s. When every position has been written, the assembled
// word is held on a valid/ready output until the consumer takes it.
// Optional feature macro: DEMUX_CAPTURE_DUP_ERR_EN (sticky duplicate-index flag).
module demux_capture #(
    parameter int unsigned N   = 8,
    parameter int unsigned S_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_bit,
    input  logic [S_W-1:0] s,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_word,
    output logic [N-1:0]   filled,
    output logic           dup_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   word_q, word_d;
    logic [N-1:0]   filled_q, filled_d;
    logic           accept;

    // Beats are taken only while collecting and never during reset.
    assign in_ready = (state_q == COLLECT) && !rst;
    assign accept   = in_valid && in_ready;

    // Next-state: write the addressed bit, go FULL once every position is set,
    // and clear everything when the consumer takes the word.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        filled_d = filled_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    word_d[s]   = in_bit;
                    filled_d[s] = 1'b1;
                    if (&filled_d) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d  = COLLECT;
                    word_d   = '0;
                    filled_d = '0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State, word and fill mask registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            word_q   <= '0;
            filled_q <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            filled_q <= filled_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_word  = word_q;
    assign filled    = filled_q;

`ifdef DEMUX_CAPTURE_DUP_ERR_EN
    logic dup_q;

    // Sticky flag: any accept to an already-written position sets it until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dup_q <= 1'b0;
        end else if (accept && filled_q[s]) begin
            dup_q <= 1'b1;
        end
    end

    assign dup_err = dup_q;
`else
    assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_capture.sv
// Directed and random self-checking bench for demux_capture (N=8).
module tb_demux_capture;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic [2:0] s;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_word;
    logic [7:0] filled;
    logic       dup_err;

    int vectors;
    int miscompares;

`ifdef DEMUX_CAPTURE_DUP_ERR_EN
    localparam logic EXP_DUP = 1'b1;
`else
    localparam logic EXP_DUP = 1'b0;
`endif

    demux_capture dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .filled    (filled),
        .dup_err   (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one beat and hold it until accepted (bounded); returns #1 after the accepting edge.
    task automatic beat(input logic [2:0] sv, input logic bv);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        s = sv;
        in_bit = bv;
        while (!acc && n < 100) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        vectors++;
        if (acc !== 1'b1) begin
            miscompares++;
            $display("FAIL beat_accept s=%0d got in_ready=%b exp 1 within 100 cycles", sv, acc);
        end
    endtask

    // Release a held word with a single out_ready cycle.
    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        vectors++;
        if (filled !== 8'h00) begin miscompares++; $display("FAIL reset_filled got %h exp 00", filled); end
        vectors++;
        if (out_word !== 8'h00) begin miscompares++; $display("FAIL reset_word got %h exp 00", out_word); end
        vectors++;
        if (dup_err !== 1'b0) begin miscompares++; $display("FAIL reset_dup got %b exp 0", dup_err); end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_ordered_fill();
        logic [7:0] bits;
        bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ordered_in_ready i=%0d got %b exp 1", i, in_ready); end
            beat(3'(i), bits[i]);
            if (i == 6) begin
                vectors++;
                if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ordered_early_valid got %b exp 0", out_valid); end
                vectors++;
                if (filled !== 8'h7F) begin miscompares++; $display("FAIL ordered_partial_filled got %h exp 7f", filled); end
            end
        end
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ordered_valid got %b exp 1", out_valid); end
        vectors++;
        if (out_word !== 8'b0100_1101) begin miscompares++; $display("FAIL ordered_word got %h exp 4d", out_word); end
        vectors++;
        if (filled !== 8'hFF) begin miscompares++; $display("FAIL ordered_filled got %h exp ff", filled); end
        drain();
        vectors++;
        if (out_valid !== 1'b0 || filled !== 8'h00) begin
            miscompares++;
            $display("FAIL ordered_drain got valid=%b filled=%h exp 0/00", out_valid, filled);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] order [8];
        order = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(order[i], 1'b1);
        in_valid = 1'b1;
        s = 3'd0;
        in_bit = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_word !== 8'hFF || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold c=%0d got valid=%b word=%h in_ready=%b exp 1/ff/0", c, out_valid, out_word, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        vectors++;
        if (filled !== 8'h00 || in_ready !== 1'b1 || out_word !== 8'h00) begin
            miscompares++;
            $display("FAIL bp_release got filled=%h in_ready=%b word=%h exp 00/1/00", filled, in_ready, out_word);
        end
    endtask

    task automatic test_duplicate();
        logic [2:0] rest [6];
        rest = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
        beat(3'd2, 1'b1);
        beat(3'd2, 1'b0);
        vectors++;
        if (filled !== 8'h04 || out_word !== 8'h00) begin
            miscompares++;
            $display("FAIL dup_overwrite got filled=%h word=%h exp 04/00", filled, out_word);
        end
        for (int i = 0; i < 6; i++) beat(rest[i], 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dup_valid_after8 got %b exp 0", out_valid); end
        beat(3'd7, 1'b0);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL dup_valid_after9 got %b exp 1", out_valid); end
        vectors++;
        if (out_word !== 8'h00) begin miscompares++; $display("FAIL dup_word got %h exp 00", out_word); end
        vectors++;
        if (dup_err !== EXP_DUP) begin miscompares++; $display("FAIL dup_err got %b exp %b", dup_err, EXP_DUP); end
        drain();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) beat(3'(i), 1'b0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        s = 3'd4;
        in_bit = 1'b1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL sim_in_ready_full got %b exp 0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || filled !== 8'h00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_release got valid=%b filled=%h in_ready=%b exp 0/00/1", out_valid, filled, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (out_word !== 8'h10 || filled !== 8'h10) begin
            miscompares++;
            $display("FAIL sim_accept got word=%h filled=%h exp 10/10", out_word, filled);
        end
        for (int i = 0; i < 8; i++) if (i != 4) beat(3'(i), 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_word !== 8'h10) begin
            miscompares++;
            $display("FAIL sim_word got valid=%b word=%h exp 1/10", out_valid, out_word);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) beat(3'(i), 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (filled !== 8'h00 || out_word !== 8'h00 || out_valid !== 1'b0 || dup_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_clear got filled=%h word=%h valid=%b dup=%b exp 00/00/0/0", filled, out_word, out_valid, dup_err);
        end
        for (int i = 0; i < 8; i++) beat(3'(7 - i), (i % 2) == 0);
        vectors++;
        if (out_valid !== 1'b1 || out_word !== 8'hAA) begin
            miscompares++;
            $display("FAIL rstmid_refill got valid=%b word=%h exp 1/aa", out_valid, out_word);
        end
        drain();
    endtask

    task automatic test_random();
        logic [2:0] perm [8];
        logic [7:0] model;
        logic [7:0] bits;
        int         j;
        logic [2:0] tmp;
        for (int w = 0; w < 1024; w++) begin
            for (int i = 0; i < 8; i++) perm[i] = 3'(i);
            for (int i = 7; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            bits = 8'($urandom);
            model = 8'h00;
            for (int i = 0; i < 8; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                beat(perm[i], bits[i]);
                model[perm[i]] = bits[i];
            end
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_word !== model) begin
                miscompares++;
                $display("FAIL rand_word w=%0d got valid=%b word=%h exp 1/%h", w, out_valid, out_word, model);
            end
            drain();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_bit = 1'b0;
        s = 3'd0;
        out_ready = 1'b0;
        test_reset();
        test_ordered_fill();
        test_backpressure();
        test_duplicate();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
